pulse_train_gen: RTL and testbench
==================================

// Module: pulse_train_gen
// PURPOSE
//  Transmit side of the single-wire pulse link: drives serial line x_out with a
//  programmable train of low->high pulses. Each pulse is one 0->1 transition,
//  so a downstream "01" pulse detector asserts its y once per generated pulse.
//  Sits between a control/test sequencer (start/params) and the serial line.
// PARAMETERS
//  CNT_W  8  width of num_pulses and of the internal pulse counter
//  LEN_W  8  width of low_len/high_len and of the internal phase counter
// PORTS
//  clk         in   1      single clock; all state on posedge clk
//  rst         in   1      synchronous, active-high reset
//  start       in   1      request; sampled only in IDLE
//  num_pulses  in   CNT_W  pulses to send; latched on accepted start
//  low_len     in   LEN_W  low-phase cycles per pulse (0 treated as 1); latched
//  high_len    in   LEN_W  high-phase cycles per pulse (0 treated as 1); latched
//  x_out       out  1      serial line; idles high
//  busy        out  1      1 while a train is in progress (LOW/HIGH states)
//  done        out  1      1-cycle completion strobe
// BEHAVIOUR
//  - One clock domain; reset is synchronous and active-high.
//  - Reset: state=IDLE; x_out=1, busy=0, done=0; counters/latched params = 0.
//  - Outputs are Moore, decoded from the state register only:
//    x_out=0 in LOW, else 1; busy=1 in LOW|HIGH; done=1 in DONE only.
//  - States: IDLE, LOW, HIGH, DONE.
//    IDLE: start=1 and num_pulses!=0 -> latch params, phase_cnt=1, pulse_cnt=1,
//          go LOW. start=1 and num_pulses==0 -> DONE (no line activity).
//          start=0 -> stay.
//    LOW:  phase_cnt==eff_low -> HIGH, phase_cnt=1; else phase_cnt++.
//    HIGH: phase_cnt==eff_high: if pulse_cnt==num -> DONE, else pulse_cnt++,
//          phase_cnt=1, -> LOW. Otherwise phase_cnt++.
//    DONE: unconditional -> IDLE (exactly one cycle).
//  - eff_low = (low_len==0) ? 1 : low_len. eff_high is derived the same way.
//    Counters never wrap. Max train is (2^CNT_W-1)*2*(2^LEN_W-1) cycles.
//  - Timing: start sampled at edge k. x_out=0 from edge k through edge
//    k+eff_low, then 1 for eff_high cycles, and so on. busy lasts
//    num*(eff_low+eff_high) cycles. done=1 in the cycle after the last high
//    phase. A new start is accepted earliest in the cycle after done.
//  - start while LOW/HIGH/DONE is ignored. Input param changes are ignored
//    after latch.
//  - Line ends a train high. Every pulse's low phase produces a fresh 0->1
//    edge. Back-to-back trains are separated by >=1 high cycle (DONE).
//  - rst mid-train: next edge returns to IDLE. x_out=1, busy=0, no done strobe.
// TESTING
//  1 rst=1 two cycles, start=1 -> x_out=1, busy=0, done=0; start ignored.
//  2 start num=1 low=2 high=3 -> x_out 0,0,1,1,1; busy 5 cycles; done=1 in cycle 6.
//  3 start num=3 low=1 high=1 -> x_out 0,1,0,1,0,1; detector model counts 3; done after.
//  4 start num=0 -> busy stays 0, x_out stays 1, done=1 the next cycle only.
//  5 num=2 low=0 high=0 -> treated as 1/1: x_out 0,1,0,1; start pulsed mid-train
//    with num=5 -> ignored, only 2 pulses sent.
//  6 num=4 low=3 high=2, rst during HIGH of pulse 2 -> next cycle x_out=1, busy=0,
//    done never asserts; fresh start num=1 low=1 high=1 -> x_out 0,1, done.

Source files
------------

// File: rtl/pulse_train_gen.sv
// Pulse train transmitter for the single-wire link: emits num_pulses low->high
// pulses on x_out with programmable low/high phase lengths, idling high.
module pulse_train_gen #(
    parameter int CNT_W = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic [LEN_W-1:0] low_len,
    input  logic [LEN_W-1:0] high_len,
    output logic             x_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] num_q;
    logic [LEN_W-1:0] low_q;
    logic [LEN_W-1:0] high_q;
    logic [LEN_W-1:0] phase_q;
    logic [CNT_W-1:0] pulse_q;
    logic             x_q;
    logic             busy_q;
    logic             done_q;

    logic [LEN_W-1:0] eff_low;
    logic [LEN_W-1:0] eff_high;

    // A zero-length phase would never produce a line transition, so it runs as one cycle.
    assign eff_low  = (low_q  == '0) ? LEN_ONE : low_q;
    assign eff_high = (high_q == '0) ? LEN_ONE : high_q;

    // Outputs are registered together with the state they decode from.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            low_q   <= '0;
            high_q  <= '0;
            phase_q <= '0;
            pulse_q <= '0;
            x_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (num_pulses != '0) begin
                            num_q   <= num_pulses;
                            low_q   <= low_len;
                            high_q  <= high_len;
                            phase_q <= LEN_ONE;
                            pulse_q <= CNT_ONE;
                            state_q <= S_LOW;
                            x_q     <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_LOW: begin
                    if (phase_q == eff_low) begin
                        phase_q <= LEN_ONE;
                        state_q <= S_HIGH;
                        x_q     <= 1'b1;
                    end else begin
                        phase_q <= phase_q + LEN_ONE;
                    end
                end
                S_HIGH: begin
                    if (phase_q == eff_high) begin
                        if (pulse_q == num_q) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            pulse_q <= pulse_q + CNT_ONE;
                            phase_q <= LEN_ONE;
                            state_q <= S_LOW;
                            x_q     <= 1'b0;
                        end
                    end else begin
                        phase_q <= phase_q + LEN_ONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    x_q     <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign x_out       = x_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Randomized bench for pulse_train_gen against a per-cycle expected waveform
// built from whole trains (low runs, high runs, done, idle gap).
module tb_pulse_train_gen;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] num_pulses;
    logic [7:0] low_len;
    logic [7:0] high_len;
    logic       x_out;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    pulse_train_gen #(.CNT_W(8), .LEN_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_pulses  (num_pulses),
        .low_len     (low_len),
        .high_len    (high_len),
        .x_out       (x_out),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    // Expected {x_out, busy, done} for each upcoming cycle.
    logic [2:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         train_num = 0;
    int         edges = 0;
    logic       prev_x = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_train(input int n, input int lo, input int hi);
        int el;
        int eh;
        el = (lo == 0) ? 1 : lo;
        eh = (hi == 0) ? 1 : hi;
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < el; i++) exp_q.push_back(3'b010);
            for (int i = 0; i < eh; i++) exp_q.push_back(3'b110);
        end
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b100);
    endtask

    task automatic cycle(input logic r, input logic st, input int n, input int lo, input int hi);
        logic [2:0] exp;
        @(negedge clk);
        rst        = r;
        start      = st;
        num_pulses = n[7:0];
        low_len    = lo[7:0];
        high_len   = hi[7:0];
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            edges = 0;
        end else if (exp_q.size() == 0 && st) begin
            push_train(n, lo, hi);
            train_num = n;
            edges = 0;
        end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b100;
        #1;
        check("outs", {29'd0, x_out, busy, done}, {29'd0, exp});
        if (prev_x === 1'b0 && x_out === 1'b1) edges++;
        prev_x = x_out;
        if (exp == 3'b101) check("pulses", edges, train_num);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 4000;
        while (exp_q.size() != 0 && budget > 0) begin
            cycle(1'b0, 1'b0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            budget--;
        end
        check("idle_budget", {31'd0, exp_q.size() == 0}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_pulses = '0; low_len = '0; high_len = '0;

        // Reset holds the line idle even with start asserted.
        cycle(1'b1, 1'b1, 5, 2, 2);
        cycle(1'b1, 1'b1, 5, 2, 2);
        cycle(1'b0, 1'b0, 0, 0, 0);

        cycle(1'b0, 1'b1, 1, 2, 3);
        wait_idle();
        cycle(1'b0, 1'b1, 3, 1, 1);
        wait_idle();
        cycle(1'b0, 1'b1, 0, 4, 4);
        wait_idle();

        // Zero lengths act as one cycle; a second start mid-train is ignored.
        cycle(1'b0, 1'b1, 2, 0, 0);
        cycle(1'b0, 1'b1, 5, 3, 3);
        wait_idle();

        // Reset during the high phase of pulse 2 drops the train without done.
        cycle(1'b0, 1'b1, 4, 3, 2);
        repeat (8) cycle(1'b0, 1'b0, 0, 0, 0);
        cycle(1'b1, 1'b0, 0, 0, 0);
        cycle(1'b0, 1'b0, 0, 0, 0);
        cycle(1'b0, 1'b1, 1, 1, 1);
        wait_idle();

        // Back-to-back starts exercise the one-cycle gap after done.
        cycle(1'b0, 1'b1, 1, 1, 1);
        repeat (6) cycle(1'b0, 1'b1, 2, 1, 2);
        wait_idle();

        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 79) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 4));
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
